// File: rtl/des_round_sequencer.sv
// rtl/des_round_sequencer.sv - DES round control FSM: load, 16 rounds, final swap, done handshake.
// Optional DES_SINGLE_STEP_EN adds a step input that gates each round and the final step.
module des_round_sequencer #(
  parameter int ROUNDS = 16,
  parameter int IDX_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             decrypt,
  input  logic             text_ready,
  input  logic             key_ready,
  input  logic             clear,
  input  logic             ack,
`ifdef DES_SINGLE_STEP_EN
  input  logic             step,
`endif
  output logic             load_en,
  output logic             round_en,
  output logic [IDX_W-1:0] round_idx,
  output logic [1:0]       shift_amt,
  output logic             shift_left,
  output logic             final_en,
  output logic             done,
  output logic             busy,
  output logic [2:0]       state
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_ROUND   = 3'd2;
  localparam logic [2:0] S_FINAL   = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  localparam logic [2:0] S_RELEASE = 3'd5;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

  logic [2:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             dec_q, dec_d;
  logic             start_q;
  logic             start_rise;
  logic             step_ok;

  assign start_rise = start & ~start_q;

`ifdef DES_SINGLE_STEP_EN
  logic step_q, step_d;
  logic step_fire_q, step_fire_d;

  always_comb begin
    step_d      = step;
    step_fire_d = step & ~step_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_q      <= 1'b0;
      step_fire_q <= 1'b0;
    end else begin
      step_q      <= step_d;
      step_fire_q <= step_fire_d;
    end
  end

  // Rounds and the final step advance only in the cycle after a step edge.
  assign step_ok = step_fire_q;
`else
  assign step_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dec_d   = dec_q;
    case (state_q)
      S_IDLE: begin
        if (start_rise && text_ready && key_ready) begin
          dec_d   = decrypt;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        idx_d   = '0;
        state_d = S_ROUND;
      end
      S_ROUND: begin
        if (step_ok) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_FINAL;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_FINAL: begin
        if (step_ok) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (ack) begin
          state_d = S_RELEASE;
        end else if (!(text_ready && key_ready)) begin
          state_d = S_IDLE;
        end
      end
      S_RELEASE: begin
        // Hold here until the operator lets go, so a held start cannot re-trigger.
        if (!ack && !start) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (clear) begin
      state_d = S_IDLE;
    end
    if (state_d == S_IDLE) begin
      idx_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      dec_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dec_q   <= dec_d;
      start_q <= start;
    end
  end

  always_comb begin
    load_en  = (state_q == S_LOAD) && !clear;
    round_en = (state_q == S_ROUND) && step_ok && !clear;
    final_en = (state_q == S_FINAL) && step_ok && !clear;
    done     = (state_q == S_DONE);
    busy     = (state_q == S_LOAD) || (state_q == S_ROUND) || (state_q == S_FINAL);
  end

  // Key-schedule rotation; decrypt skips the rotate on the first round.
  always_comb begin
    shift_amt  = 2'd0;
    shift_left = 1'b1;
    if (round_en) begin
      shift_left = ~dec_q;
      if (idx_q == IDX_W'(1) || idx_q == IDX_W'(8) || idx_q == IDX_W'(15)) begin
        shift_amt = 2'd1;
      end else if (idx_q == IDX_W'(0)) begin
        shift_amt = dec_q ? 2'd0 : 2'd1;
      end else begin
        shift_amt = 2'd2;
      end
    end
  end

  assign round_idx = idx_q;
  assign state     = state_q;

endmodule

// File: tb/tb_des_round_sequencer.sv
// tb/tb_des_round_sequencer.sv - directed self-checking bench for des_round_sequencer.
module tb_des_round_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       decrypt = 1'b0;
  logic       text_ready = 1'b0;
  logic       key_ready = 1'b0;
  logic       clear = 1'b0;
  logic       ack = 1'b0;
  logic       step = 1'b0;
  logic       load_en, round_en, shift_left, final_en, done, busy;
  logic [3:0] round_idx;
  logic [1:0] shift_amt;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;

  int enc_amt [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  int dec_amt [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  des_round_sequencer #(.ROUNDS(16), .IDX_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .decrypt    (decrypt),
    .text_ready (text_ready),
    .key_ready  (key_ready),
    .clear      (clear),
    .ack        (ack),
`ifdef DES_SINGLE_STEP_EN
    .step       (step),
`endif
    .load_en    (load_en),
    .round_en   (round_en),
    .round_idx  (round_idx),
    .shift_amt  (shift_amt),
    .shift_left (shift_left),
    .final_en   (final_en),
    .done       (done),
    .busy       (busy),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts an operation and checks every cycle up to the first DONE cycle.
  task automatic run_to_done(input logic dec, input bit toggle_mid);
    decrypt = dec;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("load_en", load_en, 1);
    chk("load_busy", busy, 1);
    chk("load_state", state, 1);
    for (int i = 0; i < 16; i++) begin
      tick();
      if (toggle_mid && i == 4) decrypt = ~decrypt;
      chk("round_en", round_en, 1);
      chk("round_idx", round_idx, i);
      chk("shift_amt", shift_amt, dec ? dec_amt[i] : enc_amt[i]);
      chk("shift_left", shift_left, !dec);
    end
    tick();
    chk("final_en", final_en, 1);
    chk("final_round_en", round_en, 0);
    tick();
    chk("done", done, 1);
    chk("done_busy", busy, 0);
    chk("done_state", state, 4);
    chk("done_final_en", final_en, 0);
  endtask

  initial begin
    #12;
    chk("rst_state", state, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_shift_left", shift_left, 1);
    chk("rst_shift_amt", shift_amt, 0);
    chk("rst_idx", round_idx, 0);
    rst = 1'b1;
    tick();
    text_ready = 1'b1;
    key_ready = 1'b1;

`ifdef DES_SINGLE_STEP_EN
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ss_load_en", load_en, 1);
    tick();
    chk("ss_wait_round_en", round_en, 0);
    for (int k = 0; k < 17; k++) begin
      step = 1'b1;
      tick();
      if (k < 16) begin
        chk("ss_round_en", round_en, 1);
        chk("ss_round_idx", round_idx, k);
      end else begin
        chk("ss_final_en", final_en, 1);
      end
      step = 1'b0;
      tick();
      chk("ss_gap_round_en", round_en, 0);
    end
    chk("ss_done", done, 1);
`else
    // Encrypt, then acknowledge
    run_to_done(1'b0, 1'b0);
    ack = 1'b1;
    tick();
    chk("rel_state", state, 5);
    chk("rel_done", done, 0);
    ack = 1'b0;
    tick();
    chk("rel_to_idle", state, 0);

    // Decrypt with decrypt toggling mid-run
    run_to_done(1'b1, 1'b1);
    decrypt = 1'b0;
    ack = 1'b1;
    clear = 1'b1;
    tick();
    chk("ack_clear_state", state, 0);
    chk("ack_clear_done", done, 0);
    ack = 1'b0;
    clear = 1'b0;

    // Start with key not ready is ignored; held start does not fire once ready
    key_ready = 1'b0;
    start = 1'b1;
    tick();
    chk("nokey_load_en", load_en, 0);
    chk("nokey_state", state, 0);
    tick();
    key_ready = 1'b1;
    tick();
    chk("held_state", state, 0);
    tick();
    chk("held_load_en", load_en, 0);
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_load_en", load_en, 1);

    // Clear at round_idx 5
    for (int i = 0; i < 6; i++) tick();
    chk("pre_clear_idx", round_idx, 5);
    clear = 1'b1;
    #1;
    chk("clear_no_strobe", round_en, 0);
    tick();
    chk("clear_state", state, 0);
    chk("clear_busy", busy, 0);
    chk("clear_idx", round_idx, 0);
    clear = 1'b0;
    tick();
    chk("clear_no_final", final_en, 0);
    chk("clear_stays_idle", state, 0);

    // Async reset mid-round at idx 7
    decrypt = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("pre_rst_idx", round_idx, 7);
    rst = 1'b0;
    #1;
    chk("mid_rst_state", state, 0);
    chk("mid_rst_idx", round_idx, 0);
    chk("mid_rst_round_en", round_en, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_shift_left", shift_left, 1);
    #1;
    rst = 1'b1;
    tick();
    run_to_done(1'b0, 1'b0);

    // Ack with start held keeps RELEASE until both fall
    start = 1'b1;
    ack = 1'b1;
    tick();
    chk("hold_rel_state", state, 5);
    ack = 1'b0;
    tick();
    chk("hold_rel_start", state, 5);
    start = 1'b0;
    tick();
    chk("hold_rel_idle", state, 0);
    tick();
    chk("hold_rel_no_load", load_en, 0);

    // Operator backspace while in DONE
    run_to_done(1'b1, 1'b0);
    text_ready = 1'b0;
    tick();
    chk("backspace_state", state, 0);
    chk("backspace_done", done, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/des_round_sequencer.md
Name: des_round_sequencer

Overview:
- Controls the iterative DES round datapath that sits downstream of hex entry.
- Waits until a full 64-bit block and a full 64-bit key have been entered, then loads both into the datapath.
- Steps through 16 rounds, driving round index, key-schedule shift amount and direction, then the final swap/IP-inverse step.
- Pulses done and holds the result for display until the operator acknowledges or clears.

Parameters:
- ROUNDS, 16, number of Feistel rounds; the shift table below is defined for 16 only.
- IDX_W, 4, width of the round index output; must satisfy 2^IDX_W >= ROUNDS.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- start  input  1  level from the "run" button/key; acted on at its rising edge only
- decrypt  input  1  0 = encrypt, 1 = decrypt; sampled on the accepted start
- text_ready  input  1  high when text entry count == 16 digits
- key_ready  input  1  high when key entry count == 16 digits
- clear  input  1  abort/clear request, level
- ack  input  1  operator acknowledge of the displayed result, level
- load_en  output  1  one-cycle strobe: datapath captures IP(text) and PC1(key)
- round_en  output  1  datapath performs one round this cycle
- round_idx  output  IDX_W  current round, 0..ROUNDS-1
- shift_amt  output  2  C/D rotate amount for this round (0, 1 or 2)
- shift_left  output  1  1 = rotate left (encrypt), 0 = rotate right (decrypt)
- final_en  output  1  one-cycle strobe: swap halves and apply IP-inverse
- done  output  1  high while the result is valid
- busy  output  1  high from the accepted start until done
- state  output  3  current state encoding, for debug LEDs

Behaviour:
- Reset (async, rst=0): state=IDLE, round_idx=0, all strobes 0, done=0, busy=0, shift_left=1, shift_amt=0, latched decrypt=0, start edge register=0.
- Start edge: start_q <= start; start_rise = start & ~start_q.
- State encoding: IDLE=0, LOAD=1, ROUND=2, FINAL=3, DONE=4, RELEASE=5. Any other value goes to IDLE on the next clock.
- IDLE:
  - On start_rise with text_ready & key_ready: latch decrypt, go to LOAD.
  - On start_rise with either ready low: ignore and stay in IDLE. No error state.
- LOAD: load_en=1, busy=1, round_idx<=0, go to ROUND.
- ROUND:
  - round_en=1 every cycle.
  - When round_idx==ROUNDS-1: go to FINAL. Otherwise round_idx<=round_idx+1.
  - Exactly 16 round_en cycles per operation.
- FINAL: final_en=1, go to DONE.
- DONE:
  - done=1, busy=0.
  - On ack: go to RELEASE.
  - If text_ready or key_ready drops (operator backspaced): go to IDLE.
- RELEASE:
  - done=0; wait while ack or start is high (held-button guard), then go to IDLE.
  - Prevents a held start from re-triggering.
- Latency: accepted start edge to done=1 is 19 cycles (LOAD 1 + 16 rounds + FINAL 1 + first DONE cycle).
- Shift table (combinational from round_idx and latched decrypt; valid while round_en=1, 0 otherwise):
  - Encrypt: shift_left=1; shift_amt=1 at idx 0, 1, 8, 15; otherwise 2.
  - Decrypt: shift_left=0; shift_amt=0 at idx 0; 1 at idx 1, 8, 15; otherwise 2.
- clear:
  - Has priority over everything except reset.
  - In any state, clear=1 sends the FSM to IDLE next cycle, with busy=0, done=0 and round_idx=0.
  - No strobe fires in the cycle clear is seen.
- decrypt changing mid-operation has no effect; only the latched copy is used.
- start_rise while busy is ignored.
- Simultaneous ack and clear in DONE: clear wins, FSM goes to IDLE, not RELEASE.

Optional Feature:
- Macro: DES_SINGLE_STEP_EN.
- Defined:
  - Adds input step (1 bit, level).
  - In ROUND, round_en asserts only in the cycle after a rising edge of step; otherwise round_idx holds.
  - FINAL is also gated by a step edge.
  - Lets the board display intermediate halves round by round.
- Undefined: no step port; rounds run back-to-back as above.

Test Plan:
- Reset mid-ROUND at round_idx=7 -> all outputs return to reset values immediately. A later start with both ready high -> normal run from idx 0.
- text_ready=1, key_ready=1, decrypt=0, start pulse -> load_en at cycle 1; round_en for 16 cycles; shift_amt sequence 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 with shift_left=1; final_en once; done=1 at cycle 19.
- Same with decrypt=1 -> shift_amt sequence 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 with shift_left=0. Toggling decrypt mid-run changes nothing.
- key_ready=0, start pulse -> stays IDLE, load_en never asserts. Start held high, then key_ready=1 -> no run until start falls and rises again.
- clear=1 at round_idx=5 -> IDLE next cycle, busy=0, no final_en. In DONE, ack and clear together -> IDLE.
- In DONE, ack=1 with start held high -> stays in RELEASE until both are low, then IDLE. With DES_SINGLE_STEP_EN, 17 step pulses are required to reach done.
